// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned shift-and-add multiplier controller.
// One Size-bit adder (add mode, carry-in 0) is reused once per iteration;
// the product appears on P together with a one-cycle done pulse.
module mult_seq_ctrl #(
  parameter int Size = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [Size-1:0]   A,
  input  logic [Size-1:0]   B,
  output logic              busy,
  output logic              done,
  output logic [2*Size-1:0] P
);

  localparam int CntW = $clog2(Size) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [Size-1:0] m;
  logic [Size-1:0] acc;
  logic [Size-1:0] q;
  logic [CntW-1:0] cnt;

  logic [Size-1:0] add_b;
  logic [Size-1:0] sum_lo;
  logic            carry;
  logic            last;

  // Shared adder: adds M into ACC only when the current multiplier bit is set
  always_comb begin
    add_b          = q[0] ? m : '0;
    {carry, sum_lo} = {1'b0, acc} + {1'b0, add_b};
    last           = (cnt == CntW'(Size - 1));
  end

  // Controller: capture operands, iterate Size times, then present the product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      P     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= A;
            q     <= B;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= {carry, sum_lo[Size-1:1]};
          q   <= {sum_lo[0], q[Size-1:1]};
          cnt <= cnt + CntW'(1);
          if (last) begin
            P     <= {carry, sum_lo, q[Size-1:1]};
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl at Size = 4, 8 and 16.
// A timing/product model is checked against all three instances every cycle,
// and directed Size=8 scenarios pin the model with literal values.
module tb_mult_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        start4, start8, start16;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy4, busy8, busy16;
  logic        done4, done8, done16;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;

  int vectors = 0;
  int miscompares = 0;

  // Model state per instance (index 0: Size 4, 1: Size 8, 2: Size 16)
  int          sz[3] = '{4, 8, 16};
  int          ph[3] = '{0, 0, 0};
  logic [63:0] opa[3];
  logic [63:0] opb[3];
  logic [63:0] mp[3] = '{64'd0, 64'd0, 64'd0};
  int          accepts[3] = '{0, 0, 0};
  int          dones8 = 0;

  logic [2:0]  st_v, bz_v, dn_v;
  logic [63:0] pv[3];
  logic [63:0] av[3];
  logic [63:0] bv[3];

  assign st_v  = {start16, start8, start4};
  assign bz_v  = {busy16, busy8, busy4};
  assign dn_v  = {done16, done8, done4};
  assign pv[0] = {56'd0, p4};
  assign pv[1] = {48'd0, p8};
  assign pv[2] = {32'd0, p16};
  assign av[0] = {60'd0, a4};
  assign av[1] = {56'd0, a8};
  assign av[2] = {48'd0, a16};
  assign bv[0] = {60'd0, b4};
  assign bv[1] = {56'd0, b8};
  assign bv[2] = {48'd0, b16};

  mult_seq_ctrl #(.Size(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .P(p4)
  );

  mult_seq_ctrl #(.Size(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .P(p8)
  );

  mult_seq_ctrl #(.Size(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .P(p16)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Compare against the model mid-cycle, then predict the effect of the next edge.
  // A started product keeps busy for Size+1 cycles; done is the last of them.
  always @(negedge clk) begin
    if (dn_v[1]) dones8++;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        ph[k] = 0;
        mp[k] = 64'd0;
      end
      check_output($sformatf("busy_s%0d", sz[k]), 64'(bz_v[k]), 64'(ph[k] != 0));
      check_output($sformatf("done_s%0d", sz[k]), 64'(dn_v[k]), 64'(ph[k] == sz[k] + 1));
      check_output($sformatf("p_s%0d", sz[k]), pv[k], mp[k]);
      if (rst_n) begin
        if (ph[k] == 0) begin
          if (st_v[k]) begin
            ph[k]  = 1;
            opa[k] = av[k];
            opb[k] = bv[k];
            accepts[k]++;
          end
        end else if (ph[k] <= sz[k]) begin
          ph[k]++;
          if (ph[k] == sz[k] + 1) mp[k] = opa[k] * opb[k];
        end else begin
          ph[k] = 0;
        end
      end
    end
  end

  // Pulse start on the Size=8 instance from an idle cycle and wait for done.
  // Leaves the caller 1 time unit into the first idle cycle after DONE.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                output int lat, output time done_at);
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    lat    = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    done_at = $time;
    @(posedge clk);
    #1;
    check_output("busy_after_done", 64'(busy8), 64'd0);
  endtask

  int  lat;
  time t1, t2;
  int  d0;
  int  cyc;

  initial begin
    start4 = 1'b0; start8 = 1'b0; start16 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    rst_n = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check_output("reset_busy", 64'(busy8), 64'd0);
    check_output("reset_done", 64'(done8), 64'd0);
    check_output("reset_p", 64'(p8), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_output("idle_p", 64'(p8), 64'd0);
    check_output("idle_busy", 64'(busy8), 64'd0);

    // Basic product and latency
    apply_stimulus(8'd13, 8'd11, lat, t1);
    check_output("basic_latency", 64'(lat), 64'd8);
    check_output("basic_p", 64'(p8), 64'd143);

    // Corners
    apply_stimulus(8'd255, 8'd255, lat, t1);
    check_output("max_p", 64'(p8), 64'd65025);
    apply_stimulus(8'd0, 8'd200, lat, t1);
    check_output("zero_a_p", 64'(p8), 64'd0);
    apply_stimulus(8'd200, 8'd0, lat, t1);
    check_output("zero_b_p", 64'(p8), 64'd0);
    apply_stimulus(8'd1, 8'd1, lat, t1);
    check_output("one_p", 64'(p8), 64'd1);
    apply_stimulus(8'd128, 8'd2, lat, t1);
    check_output("pow2_p", 64'(p8), 64'd256);

    // Busy lockout: later starts and operand changes must not disturb the run
    d0     = dones8;
    start8 = 1'b1;
    a8     = 8'd3;
    b8     = 8'd5;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      start8 = (i == 3 || i == 8);
      a8     = 8'd7;
      b8     = 8'd7;
    end
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("lockout_p", 64'(p8), 64'd15);
    check_output("lockout_dones", 64'(dones8 - d0), 64'd1);

    // Abort in the middle of a product
    d0     = dones8;
    start8 = 1'b1;
    a8     = 8'd100;
    b8     = 8'd100;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("abort_busy", 64'(busy8), 64'd0);
    check_output("abort_done", 64'(done8), 64'd0);
    check_output("abort_p", 64'(p8), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_output("abort_no_done", 64'(dones8 - d0), 64'd0);
    apply_stimulus(8'd6, 8'd7, lat, t1);
    check_output("after_abort_p", 64'(p8), 64'd42);

    // Back-to-back: second start in the first idle cycle after DONE
    apply_stimulus(8'd9, 8'd9, lat, t1);
    check_output("b2b_first_p", 64'(p8), 64'd81);
    apply_stimulus(8'd10, 8'd10, lat, t2);
    check_output("b2b_second_p", 64'(p8), 64'd100);
    check_output("b2b_spacing", 64'(t2 - t1), 64'd100);

    // Random traffic on all three sizes, checked by the model every cycle
    d0  = accepts[1];
    cyc = 0;
    accepts[0] = 0;
    accepts[2] = 0;
    while ((accepts[0] < 200 || accepts[2] < 200) && cyc < 20000) begin
      start4  = ($urandom_range(0, 2) == 0);
      start8  = ($urandom_range(0, 2) == 0);
      start16 = ($urandom_range(0, 2) == 0);
      a4  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
      b4  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      a16 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b16 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    check_output("random_s4_accepts", 64'(accepts[0] >= 200), 64'd1);
    check_output("random_s16_accepts", 64'(accepts[2] >= 200), 64'd1);
    start4 = 1'b0; start8 = 1'b0; start16 = 1'b0;
    repeat (25) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
